rm_lane_scheduler: RTL
======================

RM_LANE_SCHEDULER -- requirements
Module: rm_lane_scheduler

Interface
REQ-001 Parameter NUM_LANES, default 7, number of monitor lanes.
REQ-002 Parameter NUM_MONITORED_INS, default 2, number of monitored instruction types.
REQ-003 Parameter TIMEOUT, default 255, max busy cycles per lane; legal range 1..255.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_ni  in  1  reset, synchronous, active-low.
REQ-006 req_valid_i  in  1  monitored instruction requests a lane.
REQ-007 req_itype_i  in  $clog2(NUM_MONITORED_INS)  instruction type of request.
REQ-008 req_pc_i  in  riscv::VLEN  PC of requesting instruction.
REQ-009 req_ready_o  out  1  lane available, request accepted this cycle if valid.
REQ-010 flush_i  in  1  pipeline flush; frees all lanes.
REQ-011 lane_release_i  in  NUM_LANES  per-lane release pulse (from router lane_reset).
REQ-012 grant_valid_o  out  1  one-cycle pulse: allocation completed.
REQ-013 grant_lane_o  out  $clog2(NUM_LANES)  lane index of the grant.
REQ-014 grant_itype_o / grant_pc_o  out  as inputs  registered itype/PC of the grant.
REQ-015 lane_busy_o  out  NUM_LANES  registered per-lane occupancy.
REQ-016 lane_timeout_o  out  NUM_LANES  one-cycle pulse when a lane is force-freed by timeout.

Function
REQ-017 Each lane SHALL be FREE or BUSY; lane_busy_o SHALL reflect registered state.
REQ-018 req_ready_o SHALL be combinational: (any lane_busy_o bit == 0) && !flush_i.
REQ-019 Handshake: accept iff req_valid_i && req_ready_o; otherwise no state change from the request.
REQ-020 Selection: first FREE lane searching upward from rr_ptr, wrapping NUM_LANES-1 -> 0.
REQ-021 On accept at cycle N, at N+1: grant_valid_o=1, grant_lane_o=selected lane, grant_itype_o/grant_pc_o=captured inputs, lane BUSY, age counter=0.
REQ-022 On accept, rr_ptr SHALL become (selected+1) mod NUM_LANES; otherwise unchanged.
REQ-023 Each BUSY lane SHALL keep an 8-bit age counter, +1 per cycle, saturating at TIMEOUT.
REQ-024 BUSY lane with age == TIMEOUT-1 and no release that cycle: next cycle FREE, lane_timeout_o bit pulses 1 cycle.
REQ-025 lane_release_i bit on a BUSY lane: next cycle FREE, age=0, no timeout pulse (release wins over timeout).
REQ-026 lane_release_i on a FREE lane SHALL be ignored.
REQ-027 Selection uses registered busy only; a lane released in cycle N is not allocatable until N+1.
REQ-028 flush_i=1: next cycle all lanes FREE, ages 0, no grant, no timeout pulses; rr_ptr unchanged.
REQ-029 All lanes BUSY: req_ready_o=0; request held by requester with no loss.
REQ-030 grant_valid_o SHALL be 0 in any cycle not following an accept.

Reset
REQ-031 rst_ni=0 at clock edge: all lanes FREE, ages 0, rr_ptr=0, grant_valid_o=0, grant_lane_o=0, grant_itype_o=0, grant_pc_o=0, lane_timeout_o=0.
REQ-032 Reset SHALL override flush, release and requests in the same cycle; req_ready_o=0 while rst_ni=0.

Verification
REQ-033 After reset, req_valid_i=1 for 7 cycles -> grants on lanes 0..6 in order, lane_busy_o=7'h7F, req_ready_o=0 on 8th cycle.
REQ-034 All busy, release lane 3 at cycle N, request held -> req_ready_o=1 at N+1, grant_lane_o=3 at N+2.
REQ-035 TIMEOUT=4, one grant on lane 0, no release -> lane_timeout_o=7'h01 exactly one cycle, 4 cycles after grant; lane_busy_o[0]=0 after.
REQ-036 TIMEOUT=4, release lane 0 in same cycle age==3 -> lane freed, lane_timeout_o stays 0.
REQ-037 Lanes 0-4 busy, flush_i=1 with req_valid_i=1 -> req_ready_o=0, no grant, lane_busy_o=0 next cycle.
REQ-038 rst_ni=0 mid-operation with 3 busy lanes -> next cycle all outputs at reset values; next grant on lane 0.

Source files
------------

// File: rtl/rm_lane_scheduler_if.sv
// Request/grant bundle between a requester and the runtime-monitor lane scheduler.
// The requester drives the master side; the scheduler is the slave.
interface rm_lane_scheduler_if #(
    parameter int NUM_LANES         = 7,
    parameter int NUM_MONITORED_INS = 2,
    parameter int VLEN              = 64
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int IW = (NUM_MONITORED_INS > 1) ? $clog2(NUM_MONITORED_INS) : 1;

    logic                 req_valid_i;
    logic [IW-1:0]        req_itype_i;
    logic [VLEN-1:0]      req_pc_i;
    logic                 req_ready_o;
    logic                 flush_i;
    logic [NUM_LANES-1:0] lane_release_i;
    logic                 grant_valid_o;
    logic [LW-1:0]        grant_lane_o;
    logic [IW-1:0]        grant_itype_o;
    logic [VLEN-1:0]      grant_pc_o;
    logic [NUM_LANES-1:0] lane_busy_o;
    logic [NUM_LANES-1:0] lane_timeout_o;

    modport master (
        output req_valid_i, req_itype_i, req_pc_i, flush_i, lane_release_i,
        input  req_ready_o, grant_valid_o, grant_lane_o, grant_itype_o,
               grant_pc_o, lane_busy_o, lane_timeout_o
    );

    modport slave (
        input  req_valid_i, req_itype_i, req_pc_i, flush_i, lane_release_i,
        output req_ready_o, grant_valid_o, grant_lane_o, grant_itype_o,
               grant_pc_o, lane_busy_o, lane_timeout_o
    );
endinterface

// File: rtl/rm_lane_scheduler.sv
// Round-robin allocator of runtime-monitor lanes to monitored instructions,
// with per-lane release, watchdog timeout and pipeline flush.
module rm_lane_scheduler #(
    parameter int NUM_LANES         = 7,
    parameter int NUM_MONITORED_INS = 2,
    parameter int TIMEOUT           = 255,
    parameter int VLEN              = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    rm_lane_scheduler_if.slave bus
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int IW = (NUM_MONITORED_INS > 1) ? $clog2(NUM_MONITORED_INS) : 1;
    localparam logic [7:0] AGE_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] AGE_MAX  = 8'(TIMEOUT);

    logic [NUM_LANES-1:0] busy_q, busy_d;
    logic [NUM_LANES-1:0] timeout_q, timeout_d;
    logic [7:0]           age_q [NUM_LANES];
    logic [7:0]           age_d [NUM_LANES];
    logic [LW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [LW-1:0]        grant_lane_q, grant_lane_d;
    logic [IW-1:0]        grant_itype_q, grant_itype_d;
    logic [VLEN-1:0]      grant_pc_q, grant_pc_d;

    logic                 any_free_s;
    logic                 req_ready_s;
    logic                 accept_s;
    logic                 sel_found_s;
    logic [LW-1:0]        sel_lane_s;
    int                   idx_v;
    logic [LW-1:0]        idx_l;

    // Ready depends only on registered occupancy, so a lane freed this cycle is not yet offered.
    always_comb begin
        any_free_s  = ~(&busy_q);
        req_ready_s = any_free_s && !bus.flush_i && rst_ni;
        accept_s    = bus.req_valid_i && req_ready_s;
    end

    // Find the first free lane at or above rr_ptr, wrapping around.
    always_comb begin
        sel_found_s = 1'b0;
        sel_lane_s  = {LW{1'b0}};
        idx_v       = 0;
        idx_l       = {LW{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            idx_v = int'(rr_ptr_q) + i;
            if (idx_v >= NUM_LANES) begin
                idx_v = idx_v - NUM_LANES;
            end else begin
                idx_v = idx_v;
            end
            idx_l = LW'(idx_v);
            if (!sel_found_s && !busy_q[idx_l]) begin
                sel_found_s = 1'b1;
                sel_lane_s  = idx_l;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Per-lane occupancy and age: release beats timeout, flush beats everything.
    always_comb begin
        busy_d    = busy_q;
        timeout_d = {NUM_LANES{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            age_d[i] = age_q[i];
            if (busy_q[i]) begin
                if (bus.lane_release_i[i]) begin
                    busy_d[i] = 1'b0;
                    age_d[i]  = 8'd0;
                end else if (age_q[i] == AGE_LAST) begin
                    busy_d[i]    = 1'b0;
                    age_d[i]     = 8'd0;
                    timeout_d[i] = 1'b1;
                end else if (age_q[i] < AGE_MAX) begin
                    age_d[i] = age_q[i] + 8'd1;
                end else begin
                    age_d[i] = age_q[i];
                end
            end else begin
                age_d[i] = 8'd0;
                if (accept_s && sel_found_s && (sel_lane_s == LW'(i))) begin
                    busy_d[i] = 1'b1;
                end else begin
                    busy_d[i] = 1'b0;
                end
            end
            if (bus.flush_i) begin
                busy_d[i]    = 1'b0;
                age_d[i]     = 8'd0;
                timeout_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_d[i];
            end
        end
    end

    // Grant capture and round-robin pointer advance.
    always_comb begin
        grant_valid_d = 1'b0;
        grant_lane_d  = grant_lane_q;
        grant_itype_d = grant_itype_q;
        grant_pc_d    = grant_pc_q;
        rr_ptr_d      = rr_ptr_q;
        if (accept_s && sel_found_s) begin
            grant_valid_d = 1'b1;
            grant_lane_d  = sel_lane_s;
            grant_itype_d = bus.req_itype_i;
            grant_pc_d    = bus.req_pc_i;
            if (sel_lane_s == LW'(NUM_LANES - 1)) begin
                rr_ptr_d = {LW{1'b0}};
            end else begin
                rr_ptr_d = sel_lane_s + LW'(1);
            end
        end else begin
            grant_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q        <= {NUM_LANES{1'b0}};
            timeout_q     <= {NUM_LANES{1'b0}};
            rr_ptr_q      <= {LW{1'b0}};
            grant_valid_q <= 1'b0;
            grant_lane_q  <= {LW{1'b0}};
            grant_itype_q <= {IW{1'b0}};
            grant_pc_q    <= {VLEN{1'b0}};
            for (int i = 0; i < NUM_LANES; i++) begin
                age_q[i] <= 8'd0;
            end
        end else begin
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_valid_q <= grant_valid_d;
            grant_lane_q  <= grant_lane_d;
            grant_itype_q <= grant_itype_d;
            grant_pc_q    <= grant_pc_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign bus.req_ready_o    = req_ready_s;
    assign bus.grant_valid_o  = grant_valid_q;
    assign bus.grant_lane_o   = grant_lane_q;
    assign bus.grant_itype_o  = grant_itype_q;
    assign bus.grant_pc_o     = grant_pc_q;
    assign bus.lane_busy_o    = busy_q;
    assign bus.lane_timeout_o = timeout_q;
endmodule
